fft_bitrev_loader: RTL and testbench

// - Input stage of the radix-2 DIT FFT. Sits directly upstream of the first complex_multiplier butterfly.
// - Collects one frame of N_POINTS complex fixed_point samples in natural order and stores them at bit-reversed addresses.
// - Then streams N_POINTS/2 stage-0 butterfly pairs {top, bottom}, each with the stage-0 twiddle W^0 = 1.0.
// - The pair and twiddle drive the butterfly's input_data[1:0] and twiddle_factor directly.

---
 rtl/fft_bitrev_loader.sv | 181 ++++++++++++++++++
 tb/tb_fft_bitrev_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_loader.sv
// -----------------------------------------------------------------------------
// fft_bitrev_loader
//
// Input stage of the radix-2 DIT FFT. It collects one frame of N_POINTS
// complex samples in natural order and stores each at its bit-reversed
// address. It then streams N_POINTS/2 stage-0 butterfly pairs {top, bottom}
// straight into the first butterfly, together with the stage-0 twiddle W^0.
//
// Sample format: {real[DATA_W-1:0], imag[DATA_W-1:0]}. Both fields are signed
// Q.15, so 1.0 = 32768.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset
//   in_valid     in   in_data holds a valid sample
//   in_ready     out  loader accepts a sample this cycle (LOAD state)
//   in_data      in   sample {real, imag}
//   out_valid    out  out_data/out_twiddle hold a valid pair
//   out_ready    in   downstream accepts the pair this cycle
//   out_data     out  [0] = top (added), [1] = bottom (multiplied)
//   out_twiddle  out  constant {real = 32768, imag = 0}
//   out_last     out  marks the final pair of the frame
//
// Configuration macro FFT_LOADER_PRESCALE_EN: when defined, each accepted
// sample is arithmetic-shifted right by one on both fields before storage.
// This gives one bit of headroom for the stage-0 add/subtract.
// -----------------------------------------------------------------------------
module fft_bitrev_loader #(
  parameter int N_POINTS = 8,
  parameter int DATA_W   = 23
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2*DATA_W-1:0]          in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1:0][2*DATA_W-1:0]     out_data,
  output logic [2*DATA_W-1:0]          out_twiddle,
  output logic                         out_last
);

  localparam int AW = $clog2(N_POINTS);
  localparam int SW = 2 * DATA_W;

  localparam logic [AW-1:0]     ONE         = AW'(1);
  localparam logic [AW-1:0]     LAST_SAMPLE = AW'(N_POINTS - 1);
  localparam logic [AW-1:0]     LAST_PAIR   = AW'(N_POINTS / 2 - 1);
  localparam logic [DATA_W-1:0] TW_RE       = DATA_W'(32768);
  localparam logic [DATA_W-1:0] TW_IM       = '0;

  typedef logic [SW-1:0] sample_t;
  typedef enum logic {LOAD, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] pair_q, pair_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  sample_t [1:0] out_data_q, out_data_d;

  sample_t       mem_q [N_POINTS];
  sample_t       mem_nx [N_POINTS];

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  sample_t       wr_data;
  logic          load_pair;
  logic [AW-1:0] pair_nx;
  logic [AW-1:0] lo_addr, hi_addr;

  // Bit-reversal of an AW-bit address.
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

`ifdef FFT_LOADER_PRESCALE_EN
  logic signed [DATA_W-1:0] in_re, in_im;
  assign in_re   = in_data[SW-1:DATA_W];
  assign in_im   = in_data[DATA_W-1:0];
  // A signed >>> rounds toward -inf, so -3 becomes -2.
  assign wr_data = {in_re >>> 1, in_im >>> 1};
`else
  assign wr_data = in_data;
`endif

  assign in_ready    = (state_q == LOAD);
  assign wr_en       = !rst && (state_q == LOAD) && in_valid;
  assign wr_addr     = bitrev(wr_cnt_q);
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_data    = out_data_q;
  assign out_twiddle = {TW_RE, TW_IM};

  // NOTE: the storage array has no reset. Only the control path is reset.
  // A frame is always fully rewritten before any of it is read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    pair_d      = pair_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    load_pair   = 1'b0;
    pair_nx     = '0;

    // Memory view that includes this cycle's write. The first pair can then
    // be registered on the same edge that stores the final sample.
    // NOTE: blocking assignments here build up combinational values in order.
    // State registers take only non-blocking assignments.
    mem_nx = mem_q;
    if (wr_en) mem_nx[wr_addr] = wr_data;

    unique case (state_q)
      LOAD: begin
        if (wr_en) begin
          wr_cnt_d = wr_cnt_q + ONE;  // wraps to 0 after the last sample
          if (wr_cnt_q == LAST_SAMPLE) begin
            state_d     = DRAIN;
            out_valid_d = 1'b1;
            load_pair   = 1'b1;
            pair_nx     = '0;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (pair_q == LAST_PAIR) begin
            state_d     = LOAD;
            pair_d      = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
          end else begin
            pair_d    = pair_q + ONE;
            load_pair = 1'b1;
            pair_nx   = pair_q + ONE;
          end
        end
      end
      default: state_d = LOAD;
    endcase

    // Pair p is built from the adjacent words mem[2p] and mem[2p+1].
    lo_addr = pair_nx << 1;
    hi_addr = lo_addr | ONE;
    if (load_pair) begin
      out_data_d[0] = mem_nx[lo_addr];
      out_data_d[1] = mem_nx[hi_addr];
      out_last_d    = (pair_nx == LAST_PAIR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      wr_cnt_q    <= '0;
      pair_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      pair_q      <= pair_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// -----------------------------------------------------------------------------
// tb_fft_bitrev_loader
//
// Directed bench for fft_bitrev_loader with N_POINTS = 8 and DATA_W = 23.
// Each pair's expected contents come from a hand-written reorder table that
// lists the natural-order sample numbers of the pairs: (1,5) (3,7) (2,6) (4,8).
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point.
// -----------------------------------------------------------------------------
module tb_fft_bitrev_loader;

  localparam int N  = 8;
  localparam int DW = 23;
  localparam int SW = 2 * DW;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [SW-1:0]      in_data;
  logic               out_valid;
  logic               out_ready;
  logic [1:0][SW-1:0] out_data;
  logic [SW-1:0]      out_twiddle;
  logic               out_last;

  int checks = 0;
  int errors = 0;

  // Sample numbers (1-based) that make up each pair, in stream order.
  int ord [N] = '{1, 5, 3, 7, 2, 6, 4, 8};
  int tab_re [N];
  int tab_im [N];

  fft_bitrev_loader #(.N_POINTS(N), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_twiddle (out_twiddle),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [SW-1:0] mk(input int re, input int im);
    return {DW'(re), DW'(im)};
  endfunction

  // Expected stored form of a sample.
  function automatic logic [SW-1:0] stored(input int re, input int im);
`ifdef FFT_LOADER_PRESCALE_EN
    return mk(re >>> 1, im >>> 1);
`else
    return mk(re, im);
`endif
  endfunction

  task automatic fill(input int base);
    for (int k = 0; k < N; k++) begin
      tab_re[k] = base + k + 1;
      tab_im[k] = -(base + k + 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer the eight samples of tab_* and confirm the first pair appears one
  // cycle after the final accept. With keep = 1, in_valid stays high afterwards.
  task automatic load_frame(input bit keep);
    for (int k = 0; k < N; k++) begin
      int n = 0;
      in_valid = 1'b1;
      in_data  = mk(tab_re[k], tab_im[k]);
      while (!in_ready && n < 20) begin
        tick();
        n++;
      end
      if (n == 20) check("accept_timeout", 64'd0, 64'd1);
      check("no_pair_during_load", 64'(out_valid), 64'd0);
      tick();
    end
    if (!keep) in_valid = 1'b0;
    check("first_pair_latency", 64'(out_valid), 64'd1);
  endtask

  // Consume the four pairs. When stall_p matches a pair, out_ready is held
  // low on that pair for stall_n cycles.
  task automatic drain_frame(input int stall_p, input int stall_n);
    out_ready = 1'b1;
    for (int p = 0; p < N / 2; p++) begin
      logic [SW-1:0] e_top, e_bot;
      e_top = stored(tab_re[ord[2*p] - 1], tab_im[ord[2*p] - 1]);
      e_bot = stored(tab_re[ord[2*p+1] - 1], tab_im[ord[2*p+1] - 1]);
      check($sformatf("pair%0d_valid", p), 64'(out_valid), 64'd1);
      check($sformatf("pair%0d_top", p), 64'(out_data[0]), 64'(e_top));
      check($sformatf("pair%0d_bottom", p), 64'(out_data[1]), 64'(e_bot));
      check($sformatf("pair%0d_last", p), 64'(out_last), 64'(p == N / 2 - 1));
      check($sformatf("pair%0d_in_ready", p), 64'(in_ready), 64'd0);
      check("twiddle", 64'(out_twiddle), 64'({DW'(32768), DW'(0)}));
      if (p == stall_p) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_top", 64'(out_data[0]), 64'(e_top));
          check("stall_bottom", 64'(out_data[1]), 64'(e_bot));
          check("stall_last", 64'(out_last), 64'(p == N / 2 - 1));
          check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    check("post_frame_valid", 64'(out_valid), 64'd0);
    check("post_frame_last", 64'(out_last), 64'd0);
    check("post_frame_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = mk(55, -55);
    out_ready = 1'b1;

    // Reset is held for three cycles while in_valid is driven.
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_twiddle", 64'(out_twiddle), 64'({DW'(32768), DW'(0)}));
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_release_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("idle_out_valid", 64'(out_valid), 64'd0);

    // Reorder: real = 1..8, imag = -1..-8.
    fill(0);
    load_frame(1'b0);
    drain_frame(-1, 0);

    // Backpressure held on pair 1 for five cycles.
    fill(10);
    load_frame(1'b0);
    drain_frame(1, 5);

    // Back-to-back frames with in_valid held high. The stale sample offered
    // during DRAIN must be ignored.
    fill(20);
    load_frame(1'b1);
    drain_frame(-1, 0);
    fill(30);
    load_frame(1'b0);
    drain_frame(-1, 0);

    // Reset after five samples, then a complete new frame.
    fill(40);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = mk(tab_re[k], tab_im[k]);
      tick();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    fill(200);
    load_frame(1'b0);
    drain_frame(-1, 0);

    // Odd negative value at k = 0. With prescale this yields {-2, 3}.
    fill(60);
    tab_re[0] = -3;
    tab_im[0] = 7;
    load_frame(1'b0);
`ifdef FFT_LOADER_PRESCALE_EN
    check("prescale_top", 64'(out_data[0]), 64'(mk(-2, 3)));
`else
    check("bitexact_top", 64'(out_data[0]), 64'(mk(-3, 7)));
`endif
    drain_frame(-1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
